// File: rtl/program_sequencer.sv
// Instruction sequencer: buffers up to DEPTH datapath instructions and issues
// them over a valid/ready handshake with free-run, single-step, halt and repeat.
module program_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_load_valid,
  input  logic [INSTR_W-1:0] i_load_data,
  output logic               o_load_ready,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_halt,
  input  logic [3:0]         i_repeat,
  output logic [INSTR_W-1:0] o_instr_out,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W:0]    o_prog_len,
  output logic [3:0]         o_state,
  output logic               o_done
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_PAUSE = 4'd2,
    ST_DONE  = 4'd3
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LEN1   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PC1    = (ADDR_W)'(1);
  localparam logic [ADDR_W-1:0] LP_PC0    = (ADDR_W)'(0);
  localparam logic [ADDR_W:0]   LP_LEN0   = (ADDR_W+1)'(0);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W:0]     r_len;
  logic [3:0]          r_pass;
  logic                r_halt;
  logic [INSTR_W-1:0]  r_mem [DEPTH];

  logic                w_idle_like;
  logic                w_load_ready;
  logic                w_load_fire;
  logic [ADDR_W:0]     w_len_next;
  logic                w_handshake;
  logic                w_last;
  logic                w_halt_now;

  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_load_ready = w_idle_like && (r_len < LP_DEPTH);
  assign w_load_fire  = i_load_valid && w_load_ready && !i_clear;
  // A word accepted alongside Start counts toward the program being started.
  assign w_len_next   = w_load_fire ? (r_len + LP_LEN1) : r_len;
  assign w_handshake  = (r_state == ST_ISSUE) && i_instr_ready;
  assign w_last       = ({1'b0, r_pc} == (r_len - LP_LEN1));
  assign w_halt_now   = r_halt || i_halt;

  // Program buffer write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_load_fire) begin
      r_mem[r_len[ADDR_W-1:0]] <= i_load_data;
    end
  end

  // Sequencer state machine, PC, program length, pass counter and halt flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_pc    <= LP_PC0;
      r_len   <= LP_LEN0;
      r_pass  <= 4'd0;
      r_halt  <= 1'b0;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
      r_pc    <= LP_PC0;
      r_len   <= LP_LEN0;
      r_pass  <= 4'd0;
      r_halt  <= 1'b0;
    end else begin
      r_len <= w_len_next;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_step || i_start) begin
            if (w_len_next != LP_LEN0) begin
              r_state <= ST_ISSUE;
              r_pc    <= LP_PC0;
              r_pass  <= i_repeat;
              r_halt  <= i_step;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_handshake) begin
            r_halt <= 1'b0;
            if (w_last && (r_pass == 4'd0)) begin
              r_state <= ST_DONE;
              r_pc    <= LP_PC0;
            end else begin
              if (w_last) begin
                r_pc   <= LP_PC0;
                r_pass <= r_pass - 4'd1;
              end else begin
                r_pc   <= r_pc + LP_PC1;
              end
              r_state <= w_halt_now ? ST_PAUSE : ST_ISSUE;
            end
          end else begin
            r_halt <= w_halt_now;
          end
        end
        ST_PAUSE: begin
          if (i_step) begin
            r_state <= ST_ISSUE;
            r_halt  <= 1'b1;
          end else if (i_start) begin
            r_state <= ST_ISSUE;
            r_halt  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pc    <= LP_PC0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign o_load_ready  = w_load_ready;
  assign o_instr_out   = r_mem[r_pc];
  assign o_instr_valid = (r_state == ST_ISSUE);
  assign o_pc          = r_pc;
  assign o_prog_len    = r_len;
  assign o_state       = r_state;
  assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer.
module tb_program_sequencer;

  logic        clk;
  logic        i_reset, i_clear, i_load_valid, i_start, i_step, i_halt, i_instr_ready;
  logic [15:0] i_load_data;
  logic [3:0]  i_repeat;
  logic        o_load_ready, o_instr_valid, o_done;
  logic [15:0] o_instr_out;
  logic [3:0]  o_pc, o_state;
  logic [4:0]  o_prog_len;

  int n_checks = 0;
  int n_fail   = 0;

  program_sequencer dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_load_valid  (i_load_valid),
    .i_load_data   (i_load_data),
    .o_load_ready  (o_load_ready),
    .i_start       (i_start),
    .i_step        (i_step),
    .i_halt        (i_halt),
    .i_repeat      (i_repeat),
    .o_instr_out   (o_instr_out),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_pc          (o_pc),
    .o_prog_len    (o_prog_len),
    .o_state       (o_state),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    i_load_valid = 1'b1;
    i_load_data  = w;
    tick();
    i_load_valid = 1'b0;
  endtask

  logic [15:0] prog [3];
  logic [15:0] hs   [6];
  int          n_hs;
  logic        prev_stall;
  logic [15:0] prev_out;

  initial begin
    prog[0] = 16'h1234; prog[1] = 16'h5678; prog[2] = 16'h9ABD;
    i_reset = 1'b1; i_clear = 1'b0; i_load_valid = 1'b0; i_load_data = 16'h0000;
    i_start = 1'b0; i_step = 1'b0; i_halt = 1'b0; i_repeat = 4'd0; i_instr_ready = 1'b0;
    tick();
    i_reset = 1'b0;
    check_eq("rst_state", 32'(o_state), 32'd0);
    check_eq("rst_pc", 32'(o_pc), 32'd0);
    check_eq("rst_len", 32'(o_prog_len), 32'd0);
    check_eq("rst_valid", 32'(o_instr_valid), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_load_ready", 32'(o_load_ready), 32'd1);

    // Load and free-run
    for (int k = 0; k < 3; k++) load_word(prog[k]);
    check_eq("load_len", 32'(o_prog_len), 32'd3);
    i_repeat = 4'd0; i_instr_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("run_load_ready_busy", 32'(o_load_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check_eq("run_valid", 32'(o_instr_valid), 32'd1);
      check_eq("run_out", 32'(o_instr_out), 32'(prog[k]));
      tick();
    end
    check_eq("run_done", 32'(o_done), 32'd1);
    check_eq("run_state", 32'(o_state), 32'd3);
    check_eq("run_pc", 32'(o_pc), 32'd0);
    check_eq("run_valid_off", 32'(o_instr_valid), 32'd0);

    // Backpressure and repeat
    i_repeat = 4'd1; i_instr_ready = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_hs = 0; prev_stall = 1'b0; prev_out = 16'h0000;
    for (int c = 0; c < 40 && !o_done; c++) begin
      if (prev_stall) begin
        check_eq("bp_hold_out", 32'(o_instr_out), 32'(prev_out));
        check_eq("bp_hold_valid", 32'(o_instr_valid), 32'd1);
      end
      i_instr_ready = c[0];
      if (o_instr_valid && i_instr_ready) begin
        if (n_hs < 6) hs[n_hs] = o_instr_out;
        n_hs++;
      end
      prev_stall = o_instr_valid && !i_instr_ready;
      prev_out   = o_instr_out;
      tick();
    end
    check_eq("bp_hs_count", 32'(n_hs), 32'd6);
    for (int k = 0; k < 6 && k < n_hs; k++) check_eq("bp_hs_order", 32'(hs[k]), 32'(prog[k % 3]));
    check_eq("bp_done", 32'(o_done), 32'd1);

    // Halt during second instruction, then single step
    i_repeat = 4'd0; i_instr_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("halt_first", 32'(o_instr_out), 32'(prog[0]));
    tick();
    i_instr_ready = 1'b0; i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    tick();
    tick();
    check_eq("halt_wait_state", 32'(o_state), 32'd1);
    check_eq("halt_wait_out", 32'(o_instr_out), 32'(prog[1]));
    i_instr_ready = 1'b1;
    tick();
    check_eq("halt_state", 32'(o_state), 32'd2);
    check_eq("halt_pc", 32'(o_pc), 32'd2);
    check_eq("halt_valid", 32'(o_instr_valid), 32'd0);
    tick();
    check_eq("pause_hold", 32'(o_state), 32'd2);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    check_eq("step_valid", 32'(o_instr_valid), 32'd1);
    check_eq("step_out", 32'(o_instr_out), 32'h9ABD);
    tick();
    check_eq("step_done_state", 32'(o_state), 32'd3);
    check_eq("step_done", 32'(o_done), 32'd1);

    // Full buffer
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_eq("clr_len", 32'(o_prog_len), 32'd0);
    check_eq("clr_state", 32'(o_state), 32'd0);
    i_load_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      i_load_data = 16'(16'h1000 + k);
      tick();
    end
    i_load_valid = 1'b0;
    check_eq("full_len", 32'(o_prog_len), 32'd16);
    check_eq("full_load_ready", 32'(o_load_ready), 32'd0);
    i_repeat = 4'd0; i_instr_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_eq("full_out", 32'(o_instr_out), 32'(16'h1000 + k));
      tick();
    end
    check_eq("full_done", 32'(o_done), 32'd1);

    // Start with empty buffer
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("empty_state", 32'(o_state), 32'd3);
    check_eq("empty_valid", 32'(o_instr_valid), 32'd0);
    tick();
    check_eq("empty_valid2", 32'(o_instr_valid), 32'd0);

    // Simultaneous load and start
    i_load_valid = 1'b1; i_load_data = 16'hBEEF; i_start = 1'b1;
    tick();
    i_load_valid = 1'b0; i_start = 1'b0;
    check_eq("ls_state", 32'(o_state), 32'd1);
    check_eq("ls_len", 32'(o_prog_len), 32'd1);
    check_eq("ls_out", 32'(o_instr_out), 32'hBEEF);
    tick();
    check_eq("ls_done", 32'(o_done), 32'd1);

    // Clear mid-issue
    load_word(16'hCAFE);
    i_instr_ready = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("cm_valid", 32'(o_instr_valid), 32'd1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_eq("cm_valid_off", 32'(o_instr_valid), 32'd0);
    check_eq("cm_state", 32'(o_state), 32'd0);
    check_eq("cm_pc", 32'(o_pc), 32'd0);
    check_eq("cm_len", 32'(o_prog_len), 32'd0);
    check_eq("cm_load_ready", 32'(o_load_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
